// File: rtl/regfile_seq_pkg.sv
// Shared definitions for the register-file sequencer: op codes, FSM state
// type and the default memory-acknowledge timeout.
package regfile_seq_pkg;

    localparam logic [1:0] OP_ALU    = 2'b00;
    localparam logic [1:0] OP_CPYIN  = 2'b01;
    localparam logic [1:0] OP_CPYOUT = 2'b10;
    localparam logic [1:0] OP_LOAD   = 2'b11;

    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_MEM_WB   = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_seq_watchdog.sv
// Counts consecutive MEM_WAIT cycles and flags the cycle in which the
// TIMEOUT-th one is reached. Only instantiated when REGFILE_SEQ_TIMEOUT_EN
// is defined.
module regfile_seq_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic clear_i,
    output logic expired_o
);

    logic [7:0] cnt_q, cnt_d;

    // Zero on clear (new load), count every cycle the wait is running.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 8'd0;
        end else if (start_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = start_i && (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/regfile_sequencer.sv
// Register-file sequencer: accepts one op per valid/ready handshake, pulses
// exactly one register-file strobe per op and runs the data-memory
// request/acknowledge handshake for loads.
// Optional feature macro: REGFILE_SEQ_TIMEOUT_EN (MEM_WAIT watchdog + err).
module regfile_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic [2:0]        op_reg,
    input  logic [ADDR_W-1:0] op_addr,
    output logic              rf_cpyin,
    output logic              rf_cpyout,
    output logic              rf_comp,
    output logic              rf_mem_load,
    output logic [2:0]        rf_reg_sel,
    output logic [DATA_W-1:0] rf_load_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);

    state_e              state_q, state_d;
    logic [1:0]          opc_q, opc_d;
    logic [2:0]          reg_sel_q, reg_sel_d;
    logic [2:0]          load_reg_q, load_reg_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                accept;
    logic                load_accept;

    assign op_ready    = (state_q != ST_MEM_WAIT);
    assign accept      = op_valid && op_ready;
    assign load_accept = accept && (op_code == OP_LOAD);

`ifdef REGFILE_SEQ_TIMEOUT_EN
    logic wd_expired;
    logic err_q, err_d;

    regfile_seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (state_q == ST_MEM_WAIT),
        .clear_i   (load_accept),
        .expired_o (wd_expired)
    );

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Next-state logic; rf_reg_sel only moves when a strobe is about to fire.
    always_comb begin
        state_d    = state_q;
        opc_d      = opc_q;
        reg_sel_d  = reg_sel_q;
        load_reg_d = load_reg_q;
        addr_d     = addr_q;
        data_d     = data_q;
`ifdef REGFILE_SEQ_TIMEOUT_EN
        err_d      = 1'b0;
`endif
        case (state_q)
            ST_MEM_WAIT: begin
                // An ack on the expiry edge still completes the load.
                if (mem_ack) begin
                    data_d    = mem_rdata;
                    reg_sel_d = load_reg_q;
                    state_d   = ST_MEM_WB;
                end
`ifdef REGFILE_SEQ_TIMEOUT_EN
                else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
`endif
            end
            default: begin
                if (accept) begin
                    opc_d = op_code;
                    if (op_code == OP_LOAD) begin
                        load_reg_d = op_reg;
                        addr_d     = op_addr;
                        state_d    = ST_MEM_WAIT;
                    end else begin
                        reg_sel_d  = op_reg;
                        state_d    = ST_EXEC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State and datapath registers; async reset also drops mem_req at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            opc_q      <= OP_ALU;
            reg_sel_q  <= 3'd0;
            load_reg_q <= 3'd0;
            addr_q     <= '0;
            data_q     <= '0;
`ifdef REGFILE_SEQ_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            opc_q      <= opc_d;
            reg_sel_q  <= reg_sel_d;
            load_reg_q <= load_reg_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
`ifdef REGFILE_SEQ_TIMEOUT_EN
            err_q      <= err_d;
`endif
        end
    end

    assign rf_comp      = (state_q == ST_EXEC) && (opc_q == OP_ALU);
    assign rf_cpyin     = (state_q == ST_EXEC) && (opc_q == OP_CPYIN);
    assign rf_cpyout    = (state_q == ST_EXEC) && (opc_q == OP_CPYOUT);
    assign rf_mem_load  = (state_q == ST_MEM_WB);
    assign rf_reg_sel   = reg_sel_q;
    assign rf_load_data = data_q;
    assign mem_req      = (state_q == ST_MEM_WAIT);
    assign mem_addr     = addr_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a strobe scoreboard. The
// REGFILE_SEQ_TIMEOUT_EN section runs only when the macro is defined.
module tb_regfile_sequencer;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              op_valid;
    logic              op_ready;
    logic [1:0]        op_code;
    logic [2:0]        op_reg;
    logic [ADDR_W-1:0] op_addr;
    logic              rf_cpyin, rf_cpyout, rf_comp, rf_mem_load;
    logic [2:0]        rf_reg_sel;
    logic [DATA_W-1:0] rf_load_data;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              err;

    int n_cmp = 0;
    int n_err = 0;

    // Strobe vector layout: {comp, cpyin, cpyout, mem_load}
    typedef struct {
        logic [3:0]        s;
        logic [2:0]        r;
        logic [DATA_W-1:0] d;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    regfile_sequencer #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_code      (op_code),
        .op_reg       (op_reg),
        .op_addr      (op_addr),
        .rf_cpyin     (rf_cpyin),
        .rf_cpyout    (rf_cpyout),
        .rf_comp      (rf_comp),
        .rf_mem_load  (rf_mem_load),
        .rf_reg_sel   (rf_reg_sel),
        .rf_load_data (rf_load_data),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .busy         (busy),
        .err          (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_op(input logic [1:0] c, input logic [2:0] r, input logic [ADDR_W-1:0] a);
        op_valid = 1'b1;
        op_code  = c;
        op_reg   = r;
        op_addr  = a;
    endtask

    task automatic push_exp(input logic [3:0] s, input logic [2:0] r, input logic [DATA_W-1:0] d);
        exp_t e;
        e.s = s;
        e.r = r;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every strobe cycle must match the oldest expected entry.
    always @(negedge clk) begin
        logic [3:0] s;
        exp_t e;
        s = {rf_comp, rf_cpyin, rf_cpyout, rf_mem_load};
        if (s !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {28'd0, s}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("strobe", {28'd0, s}, {28'd0, e.s});
                chk("strobe_reg_sel", {29'd0, rf_reg_sel}, {29'd0, e.r});
                if (e.s[0]) chk("load_data", {16'd0, rf_load_data}, {16'd0, e.d});
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        op_valid  = 1'b0;
        op_code   = 2'b00;
        op_reg    = 3'd0;
        op_addr   = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_op_ready", op_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {rf_comp, rf_cpyin, rf_cpyout, rf_mem_load}, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_err", err, 0);
        chk("rst_reg_sel", rf_reg_sel, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_load_data", rf_load_data, 0);

        // Back-to-back single-cycle ops
        @(posedge clk); #1 drive_op(2'b01, 3'd3, 8'h00); push_exp(4'b0100, 3'd3, 16'h0);
        @(negedge clk); chk("b2b_ready0", op_ready, 1);
        @(posedge clk); #1 drive_op(2'b10, 3'd5, 8'h00); push_exp(4'b0010, 3'd5, 16'h0);
        @(negedge clk); chk("b2b_ready1", op_ready, 1);
        @(posedge clk); #1 drive_op(2'b00, 3'd0, 8'h00); push_exp(4'b1000, 3'd0, 16'h0);
        @(negedge clk); chk("b2b_ready2", op_ready, 1);
        @(posedge clk); #1 op_valid = 1'b0;
        @(negedge clk); chk("b2b_busy", busy, 1); chk("b2b_ready3", op_ready, 1);
        @(posedge clk); #1;
        @(negedge clk); chk("b2b_idle", busy, 0); chk("b2b_regsel_hold", rf_reg_sel, 0);

        // LOAD r6 @0x2A, ack in third MEM_WAIT cycle
        @(posedge clk); #1 drive_op(2'b11, 3'd6, 8'h2A); push_exp(4'b0001, 3'd6, 16'hBEEF);
        @(posedge clk); #1 op_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin mem_ack = 1'b1; mem_rdata = 16'hBEEF; end
            @(negedge clk);
            chk("ld_mem_req", mem_req, 1);
            chk("ld_mem_addr", mem_addr, 8'h2A);
            chk("ld_ready_low", op_ready, 0);
            chk("ld_no_wb", rf_mem_load, 0);
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        @(negedge clk);
        chk("wb_mem_req", mem_req, 0);
        chk("wb_ready", op_ready, 1);
        chk("wb_strobe", rf_mem_load, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wb_done_busy", busy, 0);
        chk("wb_data_hold", rf_load_data, 16'hBEEF);
        chk("wb_regsel_hold", rf_reg_sel, 6);

        // Stray ack in IDLE
        @(posedge clk); #1 mem_ack = 1'b1; mem_rdata = 16'h1234;
        @(posedge clk); #1 mem_ack = 1'b0;
        @(negedge clk);
        chk("stray_data", rf_load_data, 16'hBEEF);
        chk("stray_busy", busy, 0);
        chk("stray_mem_req", mem_req, 0);

        // Reset during MEM_WAIT, then late ack
        @(posedge clk); #1 drive_op(2'b11, 3'd2, 8'h11);
        @(posedge clk); #1 op_valid = 1'b0;
        @(negedge clk); chk("rstld_mem_req_pre", mem_req, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstld_mem_req_async", mem_req, 0);
        chk("rstld_busy", busy, 0);
        @(posedge clk); #1 rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h5555;
        @(posedge clk); #1 mem_ack = 1'b0;
        @(negedge clk);
        chk("rstld_idle", busy, 0);
        chk("rstld_data", rf_load_data, 0);
        chk("rstld_no_wb", rf_mem_load, 0);

`ifdef REGFILE_SEQ_TIMEOUT_EN
        // Timeout with no ack
        @(posedge clk); #1 drive_op(2'b11, 3'd1, 8'h40);
        @(posedge clk); #1 op_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_mem_req", mem_req, 1);
            chk("to_err_low", err, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_err_pulse", err, 1);
        chk("to_mem_req_drop", mem_req, 0);
        chk("to_idle", busy, 0);
        @(posedge clk); #1;
        @(negedge clk); chk("to_err_one_cycle", err, 0);

        // Ack on the expiry edge wins
        @(posedge clk); #1 drive_op(2'b11, 3'd1, 8'h41); push_exp(4'b0001, 3'd1, 16'hCAFE);
        @(posedge clk); #1 op_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin mem_ack = 1'b1; mem_rdata = 16'hCAFE; end
            @(negedge clk);
            chk("toack_mem_req", mem_req, 1);
            chk("toack_err", err, 0);
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        @(negedge clk); chk("toack_wb", rf_mem_load, 1); chk("toack_err_wb", err, 0);
        @(posedge clk); #1;
        @(negedge clk); chk("toack_err_after", err, 0);
`else
        // Without the watchdog a long wait is never abandoned
        @(posedge clk); #1 drive_op(2'b11, 3'd4, 8'h77); push_exp(4'b0001, 3'd4, 16'hA5A5);
        @(posedge clk); #1 op_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("long_mem_req", mem_req, 1);
        chk("long_err", err, 0);
        chk("long_addr", mem_addr, 8'h77);
        @(posedge clk); #1 mem_ack = 1'b1; mem_rdata = 16'hA5A5;
        @(posedge clk); #1 mem_ack = 1'b0;
        @(negedge clk); chk("long_wb", rf_mem_load, 1);
        @(posedge clk); #1;
`endif

        @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Sequencing controller for the 8-entry register file and its `res` accumulator. It accepts one register-file operation at a time over a valid/ready handshake and drives the file's control strobes, each as a one-cycle pulse. The operations are copy-in, copy-out, ALU commit and memory load. For loads it runs the data-memory request/acknowledge handshake and holds `reg_sel` stable until the loaded word is written back. It sits between instruction decode and the register file; all register-file strobes originate here.

## Interface
Parameters:
- `ADDR_W`, 8, data-memory address width
- `DATA_W`, 16, data width (matches register width)
- `TIMEOUT`, 16, max cycles waiting for `mem_ack` (used only with `REGFILE_SEQ_TIMEOUT_EN`); legal range 2..255

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `op_valid` in 1: operation offered
- `op_ready` out 1: sequencer can accept this cycle
- `op_code` in 2: operation code; 00 ALU, 01 CPYIN, 10 CPYOUT, 11 LOAD
- `op_reg` in 3: target register index
- `op_addr` in `ADDR_W`: load address; ignored for other ops
- `rf_cpyin` out 1: copy register to `res`
- `rf_cpyout` out 1: copy `res` to register
- `rf_comp` out 1: ALU result commit to `res`
- `rf_mem_load` out 1: write `rf_load_data` to register
- `rf_reg_sel` out 3: register select
- `rf_load_data` out `DATA_W`: captured memory word
- `mem_req` out 1: memory read request
- `mem_addr` out `ADDR_W`: request address
- `mem_ack` in 1: read data valid
- `mem_rdata` in `DATA_W`: read data
- `busy` out 1: not in IDLE
- `err` out 1: timeout pulse

## Operation
- States:
  - IDLE
  - EXEC: single-cycle op strobe active
  - MEM_WAIT: `mem_req` held
  - MEM_WB: `rf_mem_load` active
- Accept occurs when `op_valid && op_ready` at a rising edge. `op_ready` = 1 in IDLE, EXEC and MEM_WB, and 0 in MEM_WAIT.
- ALU/CPYIN/CPYOUT: on accept → EXEC.
  - In EXEC, exactly one of `rf_comp`/`rf_cpyin`/`rf_cpyout` = 1 and `rf_reg_sel` = `op_reg`.
  - Next state: EXEC again if another op is accepted, else IDLE.
- LOAD: on accept → MEM_WAIT.
  - `mem_req` = 1 and `mem_addr` = `op_addr` (registered), both held until `mem_ack`.
  - On the edge where `mem_ack` = 1: capture `mem_rdata` into `rf_load_data`, drop `mem_req` and go to MEM_WB.
  - In MEM_WB, `rf_mem_load` = 1 for one cycle with `rf_reg_sel` = the latched `op_reg`.
  - Next state: EXEC/MEM_WAIT if a new op is accepted, else IDLE.
- At most one `rf_*` strobe is high in any cycle.
- `rf_reg_sel` holds its last value when no strobe is active.
- `rf_load_data` holds until the next load capture.
- `mem_ack` outside MEM_WAIT is ignored (stray or late ack).
- `busy` = (state != IDLE).

## Timing
- Reset values: all strobes, `mem_req`, `busy`, `err` = 0; `rf_reg_sel`, `mem_addr`, `rf_load_data` = 0; state IDLE; `op_ready` = 1 after reset deasserts.
- Single-cycle ops: strobe in the cycle after accept (latency 1). Back-to-back accepts give one op per cycle.
- LOAD: `mem_req` rises the cycle after accept. `rf_mem_load` rises the cycle after the `mem_ack` edge. Minimum accept-to-writeback latency: 2 cycles (ack in first MEM_WAIT cycle).
- Reset mid-load: `mem_req` drops asynchronously and no writeback occurs. An ack after reset is ignored.
- `op_valid` while `op_ready` = 0: not accepted. The requester holds its op stable.

## Configuration
- `REGFILE_SEQ_TIMEOUT_EN` defined:
  - A counter runs in MEM_WAIT. After `TIMEOUT` consecutive MEM_WAIT cycles with no ack, drop `mem_req`, pulse `err` for one cycle, go to IDLE, no writeback.
  - `mem_ack` on the expiry edge wins: normal writeback, no `err`.
- Not defined: MEM_WAIT waits indefinitely. `err` is tied 0 and no counter logic exists.

## Structure
- Package `regfile_seq_pkg`: op-code constants (`OP_ALU`, `OP_CPYIN`, `OP_CPYOUT`, `OP_LOAD`), state enum type, default `TIMEOUT`.
- One sub-module, `regfile_seq_watchdog`: the MEM_WAIT cycle counter with start/clear/expired. It is instantiated only under `REGFILE_SEQ_TIMEOUT_EN`.

## Test plan
- Reset then idle: `op_ready` = 1, all outputs 0, `busy` = 0.
- Back-to-back CPYIN r3, CPYOUT r5, ALU r0 on consecutive cycles → `rf_cpyin`/`rf_cpyout`/`rf_comp` pulse on consecutive cycles with `rf_reg_sel` 3, 5, 0; `op_ready` stays 1.
- LOAD r6 addr 0x2A, `mem_ack` after 3 cycles with `mem_rdata` 0xBEEF:
  - `mem_req`/`mem_addr` = 0x2A held 3 cycles; `op_ready` = 0 throughout.
  - Then `rf_mem_load` one cycle with `rf_reg_sel` = 6 and `rf_load_data` = 0xBEEF.
- Stray `mem_ack` in IDLE with `mem_rdata` 0x1234 → no strobe; `rf_load_data` unchanged.
- `rst_n` low during MEM_WAIT, then `mem_ack` → `mem_req` 0 immediately, no `rf_mem_load`, state IDLE.
- With macro, `TIMEOUT` = 4 and no ack → `err` pulses after 4 MEM_WAIT cycles and no writeback. Repeat with ack on cycle 4 → writeback, `err` stays 0.
